// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes,
// alu_op values and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_main_fsm_imm_src_decoder.sv
// Opcode to immediate-format select; purely combinational.
module imm_src_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Main Moore control FSM of the multi-cycle RISC-V core: sequences
// fetch/decode/execute/memory/writeback and drives datapath selects.
module mc_main_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal_instr,
  output logic [3:0] state
);

  state_e state_q, state_d, out_state;
  logic   decode_ok;
  logic   pc_update, branch;
  logic   ir_write_raw, reg_write_raw, mem_write_raw;

  imm_src_decoder u_imm_src_decoder (
    .opcode  (opcode),
    .imm_src (imm_src)
  );

  always_comb begin
    state_d   = S_FETCH;
    decode_ok = 1'b1;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            decode_ok = 1'b0;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // While reset is held the datapath sees FETCH selects and no strobes,
  // including when reset lands in the middle of an instruction.
  assign out_state = reset ? S_FETCH : state_q;

  always_comb begin
    alu_op        = ALU_OP_ADD;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RD2;
    result_src    = RES_ALUOUT;
    adr_src       = 1'b0;
    ir_write_raw  = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    case (out_state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALU_OP_RTYPE;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_ITYPE;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALU_OP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign ir_write      = ir_write_raw & ~reset;
  assign reg_write     = reg_write_raw & ~reset;
  assign mem_write     = mem_write_raw & ~reset;
  assign pc_write      = ~reset & (pc_update | (branch & zero));
  assign illegal_instr = ~reset & (state_q == S_DECODE) & ~decode_ok;
  assign state         = out_state;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed bench for mc_main_fsm: instruction-level model of state paths
// and per-state control values, checked every cycle, plus literal pins.
module tb_mc_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src, imm_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, illegal_instr;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct packed {
    logic [1:0] aop, sa, sb, res;
    logic       adr, irw, pcu, br, rw, mw;
  } row_t;

  mc_main_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .imm_src       (imm_src),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .mem_write     (mem_write),
    .illegal_instr (illegal_instr),
    .state         (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Control values each state must present, straight from the state table.
  function automatic row_t row(input int st);
    case (st)
      0:  row = '{2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      1:  row = '{2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      2:  row = '{2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      3:  row = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      4:  row = '{2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      5:  row = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      6:  row = '{2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      7:  row = '{2'b11, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      8:  row = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      9:  row = '{2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      10: row = '{2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      default: row = '0;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] op);
    if (op == 7'b0100011)      return 2'b01;
    else if (op == 7'b1100011) return 2'b10;
    else if (op == 7'b1101111) return 2'b11;
    else                       return 2'b00;
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                      7'b1100011, 7'b1101111};
  endfunction

  // Whole-instruction state path; its length is the instruction's CPI.
  task automatic push_path(input logic [6:0] op, output int n);
    int p[$];
    p = '{0, 1};
    case (op)
      7'b0000011: p = '{0, 1, 2, 3, 4};
      7'b0100011: p = '{0, 1, 2, 5};
      7'b0110011: p = '{0, 1, 6, 8};
      7'b0010011: p = '{0, 1, 7, 8};
      7'b1100011: p = '{0, 1, 9};
      7'b1101111: p = '{0, 1, 10, 8};
      default:    p = '{0, 1};
    endcase
    foreach (p[k]) exp_q.push_back(p[k]);
    n = p.size();
  endtask

  task automatic check_row(input int st);
    row_t r;
    r = row(st);
    chk("state", state, st);
    chk("alu_op", alu_op, r.aop);
    chk("alu_src_a", alu_src_a, r.sa);
    chk("alu_src_b", alu_src_b, r.sb);
    chk("result_src", result_src, r.res);
    chk("adr_src", adr_src, r.adr);
    chk("ir_write", ir_write, r.irw);
    chk("reg_write", reg_write, r.rw);
    chk("mem_write", mem_write, r.mw);
    chk("pc_write", pc_write, r.pcu | (r.br & zero));
    chk("illegal_instr", illegal_instr, (st == 1) && !legal(opcode));
    chk("imm_src", imm_src, exp_imm(opcode));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_state", state, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_alu_src_a", alu_src_a, 0);
      chk("rst_alu_src_b", alu_src_b, 2);
      chk("rst_result_src", result_src, 2);
      chk("rst_adr_src", adr_src, 0);
      chk("rst_strobes", {ir_write, pc_write, reg_write, mem_write, illegal_instr}, 0);
      chk("rst_imm_src", imm_src, exp_imm(opcode));
    end else if (exp_q.size() > 0) begin
      check_row(exp_q.pop_front());
    end
  end

  // Hand-computed pins on selected cycles of each instruction.
  task automatic lit_hook(input logic [6:0] op, input logic z, input int i);
    case (op)
      7'b0000011: if (i == 4) begin
        chk("lit_lw_state", state, 4);
        chk("lit_lw_reg_write", reg_write, 1);
        chk("lit_lw_result_src", result_src, 1);
        chk("lit_lw_imm", imm_src, 0);
      end
      7'b0100011: if (i == 3) begin
        chk("lit_sw_state", state, 5);
        chk("lit_sw_mem_write", mem_write, 1);
        chk("lit_sw_adr_src", adr_src, 1);
        chk("lit_sw_imm", imm_src, 1);
      end
      7'b0110011: if (i == 2) chk("lit_r_alu_op", alu_op, 2);
      7'b0010011: if (i == 2) chk("lit_i_alu_op", alu_op, 3);
      7'b1100011: if (i == 2) begin
        chk("lit_beq_alu_op", alu_op, 1);
        chk("lit_beq_pc_write", pc_write, z ? 1 : 0);
      end
      7'b1101111: begin
        if (i == 2) begin
          chk("lit_jal_state", state, 10);
          chk("lit_jal_pc_write", pc_write, 1);
          chk("lit_jal_imm", imm_src, 3);
        end
        if (i == 3) chk("lit_jal_reg_write", reg_write, 1);
      end
      default: if (i == 1) begin
        chk("lit_ill_pulse", illegal_instr, 1);
        chk("lit_ill_state", state, 1);
      end
    endcase
  endtask

  task automatic run(input logic [6:0] op, input logic z);
    int n;
    opcode = op;
    zero   = z;
    push_path(op, n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lit_hook(op, z, i);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    opcode = 7'b0000011;
    zero   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run(7'b0000011, 1'b0);
    run(7'b0100011, 1'b0);
    run(7'b0110011, 1'b0);
    run(7'b0010011, 1'b0);
    run(7'b1100011, 1'b1);
    run(7'b1100011, 1'b0);
    run(7'b1101111, 1'b0);
    run(7'b1111111, 1'b0);
    @(negedge clk);
    chk("lit_after_ill_state", state, 0);
    chk("lit_after_ill_pulse", illegal_instr, 0);
    @(posedge clk);
    #1;
    void'(exp_q.pop_front());
    exp_q.delete();

    // Abort a store in its MEMWRITE cycle.
    opcode = 7'b0100011;
    @(negedge clk);
    chk("lit_abort_pre_state", state, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lit_abort_memadr", state, 2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("lit_abort_mem_write", mem_write, 0);
    chk("lit_abort_adr_src", adr_src, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    run(7'b0000011, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
